// File: rtl/elastic_slot_buffer.sv
// Elastic buffer holding up to NUM_SLOTS tokens in a circular slot array.
// Output is driven from registered state only; ins_ready may look through outs_ready unless READY_BREAK.
module elastic_slot_buffer #(
    parameter int DATA_TYPE   = 32,
    parameter int NUM_SLOTS   = 2,
    parameter int READY_BREAK = 0,
    localparam int CW = ($clog2(NUM_SLOTS + 1) < 1) ? 1 : $clog2(NUM_SLOTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready,
    output logic [CW-1:0]        count
);

    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [DATA_TYPE-1:0] slots [NUM_SLOTS];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic                 full;
    logic                 push;
    logic                 pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == CW'(NUM_SLOTS));
    assign outs_valid = (count != '0);
    assign outs       = slots[head];
    assign push       = ins_valid & ins_ready;
    assign pop        = outs_valid & outs_ready;

    // When full and the consumer is taking the head token, the freed slot can be refilled in the same cycle.
    always_comb begin
        ins_ready = !full;
        if (READY_BREAK == 0) begin
            ins_ready = !full | outs_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            slots <= '{default: '0};
        end else begin
            if (push) begin
                slots[tail] <= ins;
                tail        <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_elastic_slot_buffer.sv
// Drives several buffer configurations in parallel; each lane is checked against a queue-based token model.
module tb_elastic_slot_buffer;

    localparam int NL = 5;
    localparam int NS [NL] = '{3, 3, 2, 2, 1};
    localparam int RB [NL] = '{0, 1, 0, 1, 0};

    logic       clk;
    logic       rst;
    logic [7:0] ins_l        [NL];
    logic       ins_valid_l  [NL];
    logic       ins_ready_l  [NL];
    logic [7:0] outs_l       [NL];
    logic       outs_valid_l [NL];
    logic       outs_ready_l [NL];
    logic [1:0] cnt_l        [NL];

    int total;
    int bad;

    logic [7:0] q [NL][$];
    int  tok     [NL];
    int  tok_end [NL];
    int  out_idx [NL];
    bit  known   [NL];
    bit  clean   [NL];
    bit  seq_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        logic [$clog2(NS[g] + 1)-1:0] c;
        elastic_slot_buffer #(
            .DATA_TYPE  (8),
            .NUM_SLOTS  (NS[g]),
            .READY_BREAK(RB[g])
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .ins       (ins_l[g]),
            .ins_valid (ins_valid_l[g]),
            .ins_ready (ins_ready_l[g]),
            .outs      (outs_l[g]),
            .outs_valid(outs_valid_l[g]),
            .outs_ready(outs_ready_l[g]),
            .count     (c)
        );
        assign cnt_l[g] = 2'(c);
    end

    task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, g, obs, exp);
        end
    endtask

    // Inputs were applied at the falling edge; check, then advance the model across the rising edge.
    task automatic cyc();
        #1;
        for (int g = 0; g < NL; g++) begin
            int  sz;
            bit  exp_rdy;
            bit  push;
            bit  pop;
            sz      = q[g].size();
            exp_rdy = (sz != NS[g]) || (RB[g] == 0 && outs_ready_l[g] === 1'b1);
            push    = (ins_valid_l[g] === 1'b1) && exp_rdy;
            pop     = (sz != 0) && (outs_ready_l[g] === 1'b1);
            if (known[g]) begin
                check("ins_ready", g, 32'(ins_ready_l[g]), 32'(exp_rdy));
                check("outs_valid", g, 32'(outs_valid_l[g]), 32'(sz != 0));
                check("count", g, 32'(cnt_l[g]), 32'(sz));
                if (sz != 0) begin
                    check("outs", g, 32'(outs_l[g]), 32'(q[g][0]));
                end else if (clean[g]) begin
                    check("outs_after_reset", g, 32'(outs_l[g]), 32'h0);
                end
            end
            if (rst) begin
                q[g].delete();
                known[g] = 1'b1;
                clean[g] = 1'b1;
            end else if (known[g]) begin
                if (pop) begin
                    if (seq_on) begin
                        check("order", g, 32'(outs_l[g]), 32'(out_idx[g]));
                    end
                    void'(q[g].pop_front());
                    out_idx[g]++;
                end
                if (push) begin
                    q[g].push_back(ins_l[g]);
                    tok[g]++;
                    clean[g] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int ncyc, input int pv, input int pr, input logic r);
        for (int c = 0; c < ncyc; c++) begin
            rst = r;
            for (int g = 0; g < NL; g++) begin
                ins_l[g]        = 8'(tok[g]);
                ins_valid_l[g]  = (tok[g] < tok_end[g]) && ($urandom_range(99, 0) < pv);
                outs_ready_l[g] = ($urandom_range(99, 0) < pr);
            end
            cyc();
        end
    endtask

    task automatic set_tokens(input int start, input int n);
        for (int g = 0; g < NL; g++) begin
            tok[g]     = start;
            tok_end[g] = start + n;
            out_idx[g] = 0;
        end
    endtask

    function automatic bit all_done();
        for (int g = 0; g < NL; g++) begin
            if (out_idx[g] != 20) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        total  = 0;
        bad    = 0;
        seq_on = 1'b0;
        rst    = 1'b1;
        for (int g = 0; g < NL; g++) begin
            ins_l[g]        = '0;
            ins_valid_l[g]  = 1'b0;
            outs_ready_l[g] = 1'b0;
            known[g]        = 1'b0;
            clean[g]        = 1'b0;
        end
        set_tokens(0, 0);
        @(negedge clk);
        run(2, 0, 0, 1'b1);

        // Single token with consumer ready: visible exactly one cycle later.
        set_tokens(8'hA5, 1);
        run(1, 100, 100, 1'b0);
        run(3, 0, 100, 1'b0);

        // Fill under backpressure, hold the overflow token, then drain in order.
        run(1, 0, 0, 1'b1);
        set_tokens(1, 4);
        run(6, 100, 0, 1'b0);
        run(6, 100, 100, 1'b0);

        // Full buffer with both sides active: pass-through only without READY_BREAK.
        run(1, 0, 0, 1'b1);
        set_tokens(10, 8);
        run(3, 100, 0, 1'b0);
        run(4, 100, 100, 1'b0);
        run(4, 0, 100, 1'b0);

        // Reset with two tokens stored and live handshakes on both sides.
        run(1, 0, 0, 1'b1);
        set_tokens(30, 2);
        run(2, 100, 0, 1'b0);
        run(1, 100, 100, 1'b1);
        run(2, 0, 100, 1'b0);

        // Toggling outs_ready on a non-full buffer.
        run(1, 0, 0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            rst = 1'b0;
            for (int g = 0; g < NL; g++) begin
                ins_valid_l[g]  = 1'b0;
                outs_ready_l[g] = c[0];
            end
            cyc();
        end

        // Tokens 0..19 under random valid/ready.
        run(1, 0, 0, 1'b1);
        set_tokens(0, 20);
        seq_on = 1'b1;
        for (int c = 0; c < 600 && !all_done(); c++) begin
            run(1, 60, 50, 1'b0);
        end
        seq_on = 1'b0;
        for (int g = 0; g < NL; g++) begin
            check("tokens_out", g, 32'(out_idx[g]), 32'd20);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
